// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch into a small
// instruction buffer, with redirect/flush and sticky access-fault stop.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    output logic        instr_illegal,
    input  logic        instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   stale_q, stale_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0]   buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [31:0]     tag_mem [DEPTH];
    entry_t          buf_mem [DEPTH];

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_stale;
    logic            push;
    logic            pop;
    entry_t          head;

    // Circular pointer increment for a DEPTH-entry ring (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    // Request side: issue only while every slot (in flight or buffered) fits in the buffer
    assign credit_ok      = (SW'(outst_q) + SW'(occ_q)) < SW'(DEPTH);
    assign imem_req_valid = !rst && (state_q == ST_FETCH) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Response side: oldest stale_q responses belong to a flushed stream
    assign rsp_fire  = imem_rsp_valid;
    assign rsp_stale = redirect_valid | (stale_q != '0);
    assign push      = rsp_fire & ~rsp_stale;

    // Decoder-facing view of the buffer head
    assign head          = buf_mem[buf_rd_q];
    assign instr_valid   = (occ_q != '0);
    assign instr         = instr_valid ? head.data : 32'h0;
    assign instr_pc      = instr_valid ? head.pc : 32'h0;
    assign instr_fault   = instr_valid & head.err;
    assign instr_illegal = instr_valid & (head.data[1:0] != 2'b11);
    assign pop           = instr_valid & instr_ready;

    // Next-state for FSM, fetch PC, counters and pointers; redirect overrides last
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
        stale_d    = stale_q;
        occ_d      = occ_q + CW'(push) - CW'(pop);
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;

        if (req_fire) begin
            tag_wr_d   = ptr_inc(tag_wr_q);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_fire) begin
            tag_rd_d = ptr_inc(tag_rd_q);
            if (stale_q != '0) begin
                stale_d = stale_q - CW'(1);
            end
        end
        if (push) begin
            buf_wr_d = ptr_inc(buf_wr_q);
            if (imem_rsp_err) begin
                state_d = ST_FAULT;
            end
        end
        if (pop) begin
            buf_rd_d = ptr_inc(buf_rd_q);
        end
        if (redirect_valid) begin
            state_d    = ST_FETCH;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            stale_d    = outst_d;
            occ_d      = '0;
            buf_wr_d   = '0;
            buf_rd_d   = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC, credit counters and ring pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            stale_q    <= '0;
            occ_q      <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            stale_q    <= stale_d;
            occ_q      <= occ_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
        end
    end

    // Tag queue and instruction buffer storage (contents qualified by pointers/counts)
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            buf_mem[buf_wr_q] <= {imem_rsp_data, tag_mem[tag_rd_q], imem_rsp_err};
        end
    end

`ifdef FORMAL
    // A response must always match an outstanding request
    always_comb begin
        if (!rst && imem_rsp_valid) begin
            assert (outst_q != '0);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: per-cycle vector table plus redirect,
// fault, async-reset and PC-wrap sequences.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_illegal;
    logic        instr_ready;

    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc    = 32'h0;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_req_ready      = 1'b1;
    logic        w_rsp_valid      = 1'b0;
    logic [31:0] w_rsp_data       = 32'h0;
    logic        w_rsp_err        = 1'b0;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_instr_fault;
    logic        w_instr_illegal;
    logic        w_instr_ready    = 1'b1;

    int          n_vec = 0;
    int          n_err = 0;
    logic        rsp_en;
    logic [31:0] err_addr;
    logic [31:0] pend [$];
    logic        w_hs_s;
    logic [31:0] w_a_s;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_fault(instr_fault), .instr_illegal(instr_illegal),
        .instr_ready(instr_ready)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) u_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(w_req_ready),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .imem_rsp_err(w_rsp_err),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_fault(w_instr_fault), .instr_illegal(w_instr_illegal),
        .instr_ready(w_instr_ready)
    );

    // Memory contents: one all-zero (illegal) word at 0x14, otherwise legal 32-bit encodings
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0014) return 32'h0;
        return {a[31:2] ^ 30'h2AAA_AAAA, 2'b11};
    endfunction

    // In-order memory model for the main DUT: 1-cycle latency, can be held off with rsp_en
    always begin
        @(negedge clk);
        if (rst) pend.delete();
        else if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
        @(posedge clk);
        #1;
        if (!rst && rsp_en && pend.size() > 0) begin
            logic [31:0] a;
            a = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(a);
            imem_rsp_err   = (a == err_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_rsp_err   = 1'b0;
        end
    end

    // Always-ready 1-cycle memory model for the wrap instance
    always begin
        @(negedge clk);
        w_hs_s = w_req_valid & w_req_ready;
        w_a_s  = w_req_addr;
        @(posedge clk);
        #1;
        w_rsp_valid = w_hs_s & ~rst;
        w_rsp_data  = mem_word(w_a_s);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Compare main DUT outputs; pc/data/fault only matter while the head is valid
    task automatic chk_io(input string nm, input logic erv, input logic [31:0] era,
                          input logic eiv, input logic [31:0] eipc, input logic eflt);
        logic [31:0]  w;
        logic         eill;
        logic [127:0] g;
        logic [127:0] e;
        w    = mem_word(eipc);
        eill = eiv && (w[1:0] != 2'b11);
        if (eiv) begin
            g = 128'({imem_req_valid, imem_req_addr, instr_valid, instr_pc, instr_fault, instr_illegal, instr});
            e = 128'({erv, era, 1'b1, eipc, eflt, eill, w});
        end else begin
            g = 128'({imem_req_valid, imem_req_addr, instr_valid, instr_illegal});
            e = 128'({erv, era, 1'b0, 1'b0});
        end
        chk(nm, g, e);
    endtask

    task automatic chk_rst(input string nm);
        chk(nm, 128'({imem_req_valid, imem_req_addr, instr_valid, instr_pc, instr_fault, instr_illegal, instr}),
                128'({1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        ir;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic ir, input logic rv,
                                input logic [31:0] ra, input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.ir = ir; v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    vec_t tbl [30];

    initial begin
        logic [31:0] wreq_a [3];
        logic [31:0] wpc    [4];

        // Streaming with DEPTH=2 (credit-limited), then 10 cycles of decoder stall, then release
        tbl[0]  = mk(1, 1, 1, 32'd0,  0, 32'd0);
        tbl[1]  = mk(1, 1, 1, 32'd4,  0, 32'd0);
        tbl[2]  = mk(1, 1, 0, 32'd8,  1, 32'd0);
        tbl[3]  = mk(1, 1, 1, 32'd8,  1, 32'd4);
        tbl[4]  = mk(1, 1, 1, 32'd12, 0, 32'd0);
        tbl[5]  = mk(1, 1, 0, 32'd16, 1, 32'd8);
        tbl[6]  = mk(1, 1, 1, 32'd16, 1, 32'd12);
        tbl[7]  = mk(1, 1, 1, 32'd20, 0, 32'd0);
        tbl[8]  = mk(1, 1, 0, 32'd24, 1, 32'd16);
        tbl[9]  = mk(1, 1, 1, 32'd24, 1, 32'd20);
        tbl[10] = mk(1, 0, 1, 32'd28, 0, 32'd0);
        for (int i = 11; i < 20; i++) tbl[i] = mk(1, 0, 0, 32'd32, 1, 32'd24);
        tbl[20] = mk(1, 1, 0, 32'd32, 1, 32'd24);
        tbl[21] = mk(1, 1, 1, 32'd32, 1, 32'd28);
        tbl[22] = mk(1, 1, 1, 32'd36, 0, 32'd0);
        tbl[23] = mk(1, 1, 0, 32'd40, 1, 32'd32);
        tbl[24] = mk(1, 1, 1, 32'd40, 1, 32'd36);
        tbl[25] = mk(0, 1, 1, 32'd44, 0, 32'd0);
        tbl[26] = mk(0, 1, 1, 32'd44, 1, 32'd40);
        tbl[27] = mk(1, 1, 1, 32'd44, 0, 32'd0);
        tbl[28] = mk(1, 1, 1, 32'd48, 0, 32'd0);
        tbl[29] = mk(1, 1, 0, 32'd52, 1, 32'd44);

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        rsp_en         = 1'b1;
        err_addr       = 32'hFFFF_FFFF;
        #3;
        chk_rst("reset_hold");
        chk("wrap_reset_addr", 128'({w_req_valid, w_req_addr}), 128'({1'b0, 32'hFFFF_FFF8}));

        do_reset();
        for (int i = 0; i < 30; i++) begin
            imem_req_ready = tbl[i].rdy;
            instr_ready    = tbl[i].ir;
            @(negedge clk);
            chk_io($sformatf("vec%0d", i), tbl[i].rv, tbl[i].ra, tbl[i].iv, tbl[i].ipc, 1'b0);
            tick();
        end

        // Redirect with two requests outstanding, then redirect against an arriving response
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        rsp_en         = 1'b0;
        do_reset();
        @(negedge clk); chk_io("rd_c0", 1, 32'h0, 0, 0, 0); tick();
        @(negedge clk); chk_io("rd_c1", 1, 32'h4, 0, 0, 0); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        rsp_en         = 1'b1;
        @(negedge clk); chk("rd_redir_noreq", 128'(imem_req_valid), 128'(1'b0)); tick();
        redirect_valid = 1'b0;
        @(negedge clk); chk_io("rd_drop0", 0, 32'h1000, 0, 0, 0); tick();
        @(negedge clk); chk_io("rd_drop1", 1, 32'h1000, 0, 0, 0); tick();
        @(negedge clk); chk_io("rd_c5", 1, 32'h1004, 0, 0, 0); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(negedge clk);
        chk("rd_c6_head", 128'({imem_req_valid, instr_valid, instr_pc}), 128'({1'b0, 1'b1, 32'h1000}));
        tick();
        redirect_valid = 1'b0;
        @(negedge clk); chk_io("rd_flush", 1, 32'h200, 0, 0, 0); tick();
        @(negedge clk); chk_io("rd_c8", 1, 32'h204, 0, 0, 0); tick();
        @(negedge clk); chk_io("rd_c9", 0, 32'h208, 1, 32'h200, 0); tick();

        // Access fault at 0x8: in-flight 0xC still buffered, fetch stops until redirect to 0x40
        err_addr = 32'h0000_0008;
        do_reset();
        tick(); tick(); tick(); tick();
        @(negedge clk); chk_io("ft_c4", 1, 32'hC, 0, 0, 0); tick();
        @(negedge clk); chk_io("ft_entry", 0, 32'h10, 1, 32'h8, 1); tick();
        @(negedge clk); chk_io("ft_inflight", 0, 32'h10, 1, 32'hC, 0); tick();
        @(negedge clk); chk_io("ft_stop7", 0, 32'h10, 0, 0, 0); tick();
        @(negedge clk); chk_io("ft_stop8", 0, 32'h10, 0, 0, 0); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        @(negedge clk); chk("ft_redir_noreq", 128'(imem_req_valid), 128'(1'b0)); tick();
        redirect_valid = 1'b0;
        err_addr       = 32'hFFFF_FFFF;
        @(negedge clk); chk_io("ft_resume", 1, 32'h40, 0, 0, 0); tick();
        @(negedge clk); chk_io("ft_c11", 1, 32'h44, 0, 0, 0); tick();
        @(negedge clk); chk_io("ft_c12", 0, 32'h48, 1, 32'h40, 0);

        // Asynchronous reset between edges while the buffer holds an entry
        #3;
        rst = 1'b1;
        #1;
        chk_rst("async_rst");

        // Wrap instance: FFFF_FFF8, FFFF_FFFC, 0, 4 delivered one per cycle
        wreq_a[0] = 32'hFFFF_FFF8; wreq_a[1] = 32'hFFFF_FFFC; wreq_a[2] = 32'h0000_0000;
        wpc[0]    = 32'hFFFF_FFF8; wpc[1]    = 32'hFFFF_FFFC; wpc[2]    = 32'h0000_0000;
        wpc[3]    = 32'h0000_0004;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 3) begin
                chk($sformatf("wrap_req%0d", c), 128'({w_req_valid, w_req_addr}), 128'({1'b1, wreq_a[c]}));
            end
            if (c >= 2) begin
                chk($sformatf("wrap_out%0d", c),
                    128'({w_instr_valid, w_instr_pc, w_instr}),
                    128'({1'b1, wpc[c-2], mem_word(wpc[c-2])}));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
